// File: rtl/horner_multiply_adder.sv
// One Horner step per request: acc <- sat(((acc * x) >>> FRAC) + a[sel]).
// The multiply is a sign-magnitude shift-add, one multiplier bit per cycle.
module horner_multiply_adder #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 14,
    parameter int NUM_COEF = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    adc_input_ready,
    input  logic                    multiplyadder_in_ready,
    input  logic [3:0]              coefficent_select,
    input  logic                    coef_wr_en,
    input  logic [3:0]              coef_wr_addr,
    input  logic signed [WIDTH-1:0] coef_wr_data,
    output logic                    multiplyadder_out_ready,
    output logic signed [WIDTH-1:0] acc_out,
    output logic                    busy,
    output logic                    overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [3:0] COEF_LIMIT = 4'(NUM_COEF);
    localparam logic signed [PW:0] SAT_MAX = (PW+1)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, SAMPLE, MULT, ADD} state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] coef;
    logic signed [WIDTH-1:0] bank [NUM_COEF];
    logic [WIDTH-1:0]        mplier;
    logic [PW-1:0]           mcand;
    logic [PW-1:0]           prod;
    logic                    prod_neg;
    logic [CW-1:0]           cnt;

    logic [WIDTH-1:0]        mag_acc;
    logic [WIDTH-1:0]        mag_x;
    logic signed [PW:0]      prod_signed;
    logic signed [PW:0]      prod_shifted;
    logic signed [PW:0]      sum;
    logic signed [WIDTH-1:0] sat_result;

    // -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which still fits unsigned in WIDTH bits
    always_comb begin
        mag_acc      = acc[WIDTH-1] ? $unsigned(-acc) : $unsigned(acc);
        mag_x        = x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
        prod_signed  = prod_neg ? -$signed({1'b0, prod}) : $signed({1'b0, prod});
        prod_shifted = prod_signed >>> FRAC;
        sum          = prod_shifted + (PW+1)'(coef);
        if (sum > SAT_MAX)
            sat_result = WIDTH'(SAT_MAX);
        else if (sum < SAT_MIN)
            sat_result = WIDTH'(SAT_MIN);
        else
            sat_result = WIDTH'(sum);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_COEF; i++)
                bank[i] <= '0;
        end else if (coef_wr_en && coef_wr_addr < COEF_LIMIT) begin
            bank[coef_wr_addr] <= coef_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                   <= IDLE;
            acc                     <= '0;
            x                       <= '0;
            coef                    <= '0;
            mplier                  <= '0;
            mcand                   <= '0;
            prod                    <= '0;
            prod_neg                <= 1'b0;
            cnt                     <= '0;
            acc_out                 <= '0;
            multiplyadder_out_ready <= 1'b0;
            busy                    <= 1'b0;
            overrun                 <= 1'b0;
        end else begin
            multiplyadder_out_ready <= 1'b0;
            if (state != IDLE && (adc_input_ready || multiplyadder_in_ready))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (adc_input_ready) begin
                        x   <= x_in;
                        acc <= '0;
                    end
                    if (multiplyadder_in_ready) begin
                        state <= SAMPLE;
                        busy  <= 1'b1;
                    end
                end
                SAMPLE: begin
                    coef     <= (coefficent_select < COEF_LIMIT) ? bank[coefficent_select] : '0;
                    mcand    <= {{WIDTH{1'b0}}, mag_acc};
                    mplier   <= mag_x;
                    prod_neg <= acc[WIDTH-1] ^ x[WIDTH-1];
                    prod     <= '0;
                    cnt      <= '0;
                    state    <= MULT;
                end
                MULT: begin
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= ADD;
                end
                ADD: begin
                    acc                     <= sat_result;
                    acc_out                 <= sat_result;
                    multiplyadder_out_ready <= 1'b1;
                    busy                    <= 1'b0;
                    state                   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_horner_multiply_adder.sv
// Randomized and directed checks of horner_multiply_adder against a plain
// arithmetic model of the Horner recurrence with saturation and floor shift.
module tb_horner_multiply_adder;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] x_in;
    logic               adc_input_ready;
    logic               multiplyadder_in_ready;
    logic [3:0]         coefficent_select;
    logic               coef_wr_en;
    logic [3:0]         coef_wr_addr;
    logic signed [15:0] coef_wr_data;
    logic               multiplyadder_out_ready;
    logic signed [15:0] acc_out;
    logic               busy;
    logic               overrun;

    int vectors    = 0;
    int miscompares = 0;
    int pulses     = 0;

    int acc_m;
    int x_m;
    int accout_m;
    int bank_m [11];

    horner_multiply_adder #(.WIDTH(16), .FRAC(14), .NUM_COEF(11)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .x_in                    (x_in),
        .adc_input_ready         (adc_input_ready),
        .multiplyadder_in_ready  (multiplyadder_in_ready),
        .coefficent_select       (coefficent_select),
        .coef_wr_en              (coef_wr_en),
        .coef_wr_addr            (coef_wr_addr),
        .coef_wr_data            (coef_wr_data),
        .multiplyadder_out_ready (multiplyadder_out_ready),
        .acc_out                 (acc_out),
        .busy                    (busy),
        .overrun                 (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (multiplyadder_out_ready === 1'b1)
            pulses++;

    function automatic int rand16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    function automatic int coef_m(input int sel);
        return (sel < 11) ? bank_m[sel] : 0;
    endfunction

    // Reference: floor((acc * x) / 2^14) + a, clamped to the 16-bit signed range
    function automatic int step_m(input int a, input int xv, input int c);
        longint s;
        s = ((longint'(a) * longint'(xv)) >>> 14) + longint'(c);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        acc_m = 0;
        x_m = 0;
        accout_m = 0;
        for (int i = 0; i < 11; i++) bank_m[i] = 0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();
    endtask

    task automatic writeCoef(input int addr, input int data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 4'(addr);
        coef_wr_data = 16'(data);
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        if (addr < 11) bank_m[addr] = int'($signed(16'(data)));
    endtask

    task automatic loadX(input int v);
        x_in            = 16'(v);
        adc_input_ready = 1'b1;
        @(posedge clk);
        #1;
        adc_input_ready = 1'b0;
        x_m   = v;
        acc_m = 0;
        checkOutput("acc_hold_on_load", longint'(acc_out), longint'(accout_m));
    endtask

    // One Horner step; optional simultaneous load, overrun strobe, mid-MULT reset,
    // or a coefficient write landing in the same cycle as the bank read
    task automatic applyStimulus(input int sel, input bit sim_load = 0, input int new_x = 0,
                                 input bit inj_overrun = 0, input bit inj_reset = 0,
                                 input bit wr_same = 0, input int wr_data = 0);
        int lat;
        bit changed;
        int exp;
        logic signed [15:0] prev;
        prev = acc_out;
        multiplyadder_in_ready = 1'b1;
        if (sim_load) begin
            adc_input_ready = 1'b1;
            x_in = 16'(new_x);
        end
        @(posedge clk);
        #1;
        multiplyadder_in_ready = 1'b0;
        adc_input_ready = 1'b0;
        coefficent_select = 4'(sel);
        if (sim_load) begin
            x_m = new_x;
            acc_m = 0;
        end
        if (wr_same) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 4'(sel);
            coef_wr_data = 16'(wr_data);
        end
        lat = 0;
        changed = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                coef_wr_en = 1'b0;
                checkOutput("busy_running", longint'(busy), 1);
            end
            if (inj_overrun && i == 4) multiplyadder_in_ready = 1'b1;
            if (i == 5) multiplyadder_in_ready = 1'b0;
            if (inj_reset && i == 7) reset = 1'b0;
            if (inj_reset && i == 8) begin
                checkOutput("reset_acc_out", longint'(acc_out), 0);
                checkOutput("reset_busy", longint'(busy), 0);
                checkOutput("reset_out_ready", longint'(multiplyadder_out_ready), 0);
                reset = 1'b1;
                modelReset();
                return;
            end
            if (multiplyadder_out_ready === 1'b1) begin
                lat = i;
                break;
            end
            if (acc_out !== prev) changed = 1;
        end
        exp = step_m(acc_m, x_m, coef_m(sel));
        acc_m = exp;
        accout_m = exp;
        if (wr_same && sel < 11) bank_m[sel] = int'($signed(16'(wr_data)));
        checkOutput("latency", longint'(lat), 18);
        checkOutput("early_acc_change", longint'(changed), 0);
        checkOutput("acc_out", longint'(acc_out), longint'(exp));
        checkOutput("busy_done", longint'(busy), 0);
        @(posedge clk);
        #1;
        checkOutput("pulse_width", longint'(multiplyadder_out_ready), 0);
    endtask

    task automatic runSteps(input int top, input int bottom);
        for (int s = top; s >= bottom; s--) applyStimulus(s);
    endtask

    initial begin
        int p0;
        int xv;
        reset = 1'b0;
        x_in = '0;
        adc_input_ready = 1'b0;
        multiplyadder_in_ready = 1'b0;
        coefficent_select = '0;
        coef_wr_en = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        modelReset();

        doReset();
        checkOutput("rst_acc_out", longint'(acc_out), 0);
        checkOutput("rst_out_ready", longint'(multiplyadder_out_ready), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_overrun", longint'(overrun), 0);

        $display("[TB] identity polynomial");
        writeCoef(1, 16384);
        loadX(8192);
        p0 = pulses;
        runSteps(10, 0);
        checkOutput("identity_result", longint'(acc_out), 8192);
        checkOutput("identity_pulses", longint'(pulses - p0), 11);

        $display("[TB] latency");
        doReset();
        writeCoef(10, 1000);
        loadX(16384);
        applyStimulus(10);
        checkOutput("latency_result", longint'(acc_out), 1000);

        $display("[TB] saturation");
        doReset();
        writeCoef(10, 32767);
        writeCoef(9, 32767);
        loadX(16384);
        runSteps(10, 9);
        checkOutput("sat_pos", longint'(acc_out), 32767);
        writeCoef(10, -32768);
        writeCoef(9, -32768);
        loadX(16384);
        runSteps(10, 9);
        checkOutput("sat_neg", longint'(acc_out), -32768);

        $display("[TB] floor rounding");
        writeCoef(10, -1);
        writeCoef(9, 0);
        loadX(1);
        runSteps(10, 9);
        checkOutput("floor_pos_x", longint'(acc_out), -1);
        loadX(-1);
        runSteps(10, 9);
        checkOutput("floor_neg_x", longint'(acc_out), 0);

        $display("[TB] overrun");
        checkOutput("overrun_clear", longint'(overrun), 0);
        writeCoef(10, 1000);
        loadX(5);
        p0 = pulses;
        applyStimulus(10, 0, 0, 1);
        checkOutput("overrun_set", longint'(overrun), 1);
        checkOutput("overrun_result", longint'(acc_out), 1000);
        repeat (25) @(posedge clk);
        #1;
        checkOutput("overrun_pulses", longint'(pulses - p0), 1);
        checkOutput("overrun_sticky", longint'(overrun), 1);

        $display("[TB] reset mid-MULT");
        writeCoef(5, 1234);
        loadX(100);
        applyStimulus(10, 0, 0, 0, 1);
        p0 = pulses;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("post_reset_pulses", longint'(pulses - p0), 0);
        checkOutput("post_reset_overrun", longint'(overrun), 0);
        applyStimulus(5);
        checkOutput("coef_cleared", longint'(acc_out), 0);

        $display("[TB] randomized polynomials");
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 11; a++)
                writeCoef(a, (r % 2 == 1) ? rand16() : (rand16() >>> 3));
            writeCoef(11 + int'($urandom_range(0, 4)), rand16());
            xv = rand16();
            if (r % 3 != 0) loadX(xv);
            for (int s = 10; s >= 0; s--) begin
                int sel;
                bit wr;
                sel = ($urandom_range(0, 9) == 0) ? 11 + int'($urandom_range(0, 4)) : s;
                wr  = ($urandom_range(0, 4) == 0);
                applyStimulus(sel, (r % 3 == 0) && (s == 10), xv, 0, 0, wr, rand16());
            end
            checkOutput("rand_overrun", longint'(overrun), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
